// File: rtl/kamus_csr_file_if.sv
// CSR read/write port between the execute/write-back stages and the machine-mode CSR file.
// The core side drives requests (master); the CSR file answers them (slave).
interface kamus_csr_file_if;
  logic [11:0] rd_addr_i;
  logic [31:0] rd_data_o;
  logic        rd_illegal_o;
  logic        wr_valid_i;
  logic [1:0]  wr_op_i;
  logic [11:0] wr_addr_i;
  logic [31:0] wr_src_i;
  logic        wr_src_zero_i;
  logic        wr_illegal_o;
  logic        retire_i;
  logic        trap_i;
  logic [31:0] trap_pc_i;
  logic [31:0] trap_cause_i;
  logic [31:0] trap_tval_i;
  logic        mret_i;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_global_o;
  logic        irq_pending_o;

  modport master (
    output rd_addr_i, wr_valid_i, wr_op_i, wr_addr_i, wr_src_i, wr_src_zero_i,
           retire_i, trap_i, trap_pc_i, trap_cause_i, trap_tval_i, mret_i,
    input  rd_data_o, rd_illegal_o, wr_illegal_o, mtvec_o, mepc_o, mie_global_o, irq_pending_o
  );

  modport slave (
    input  rd_addr_i, wr_valid_i, wr_op_i, wr_addr_i, wr_src_i, wr_src_zero_i,
           retire_i, trap_i, trap_pc_i, trap_cause_i, trap_tval_i, mret_i,
    output rd_data_o, rd_illegal_o, wr_illegal_o, mtvec_o, mepc_o, mie_global_o, irq_pending_o
  );
endinterface

// File: rtl/kamus_csr_file.sv
// Machine-mode CSR file: combinational read port, CSRRW/RS/RC write side, 64-bit
// cycle/instret/timecmp counters, trap entry / MRET state and timer interrupt pending.
module kamus_csr_file #(
  parameter logic [31:0] MISA_VALUE      = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET     = 32'h0000_0000,
  parameter logic [11:0] TIMECMP_ADDR_LO = 12'h7C0,
  parameter logic [11:0] TIMECMP_ADDR_HI = 12'h7C1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  kamus_csr_file_if.slave csr
);

  localparam logic [11:0] A_MSTATUS   = 12'h300, A_MISA     = 12'h301, A_MEDELEG  = 12'h302;
  localparam logic [11:0] A_MIDELEG   = 12'h303, A_MIE      = 12'h304, A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340, A_MEPC     = 12'h341, A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MBADADDR  = 12'h343, A_MIP      = 12'h344, A_MTIME    = 12'h701;
  localparam logic [11:0] A_MTIMEH    = 12'h741, A_DSCRATCH = 12'h7B2, A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02, A_MCYCLEH  = 12'hB80, A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00, A_TIME     = 12'hC01, A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_TIMEH     = 12'hC81, A_MVENDORID = 12'hF11, A_MARCHID = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13, A_MHARTID  = 12'hF14;

  localparam logic [1:0] OP_RW = 2'b01, OP_RS = 2'b10;

  logic [63:0] cycles, instret, timecmp;
  logic [31:0] mscratch, dscratch, mepc, mbadaddr, mtvec;
  logic        mcause_irq;
  logic [3:0]  mcause_code;
  logic        mie_g, mpie, msip;
  logic [2:0]  mie_en;        // {meie, mtie, msie}
  logic        wr_illegal_q;
  logic        mtip;

  assign mtip = (cycles >= timecmp);

  // Returns {unmapped, data}; shared by the execute read port and the write-side RMW.
  function automatic logic [32:0] csr_rd(input logic [11:0] a);
    logic [31:0] d;
    logic        bad;
    d   = '0;
    bad = 1'b0;
    case (a)
      A_MVENDORID, A_MARCHID, A_MIMPID, A_MHARTID, A_MEDELEG, A_MIDELEG: d = '0;
      A_MISA:      d = MISA_VALUE;
      A_MSTATUS:   d = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie_g, 3'b0};
      A_MIE:       d = {20'b0, mie_en[2], 3'b0, mie_en[1], 3'b0, mie_en[0], 3'b0};
      A_MIP:       d = {20'b0, 1'b0, 3'b0, mtip, 3'b0, msip, 3'b0};
      A_MTVEC:     d = {mtvec[31:2], 2'b0};
      A_MSCRATCH:  d = mscratch;
      A_MEPC:      d = {mepc[31:2], 2'b0};
      A_MCAUSE:    d = {mcause_irq, 27'b0, mcause_code};
      A_MBADADDR:  d = mbadaddr;
      A_DSCRATCH:  d = dscratch;
      A_MCYCLE, A_MTIME, A_CYCLE, A_TIME:     d = cycles[31:0];
      A_MCYCLEH, A_MTIMEH, A_CYCLEH, A_TIMEH: d = cycles[63:32];
      A_MINSTRET:  d = instret[31:0];
      A_MINSTRETH: d = instret[63:32];
      TIMECMP_ADDR_LO: d = timecmp[31:0];
      TIMECMP_ADDR_HI: d = timecmp[63:32];
      default:     bad = 1'b1;
    endcase
    return {bad, d};
  endfunction

  logic [32:0] rd_res, wr_res;
  logic [31:0] wr_old, wr_new;
  logic        wr_unmapped, wr_ro, wr_en, wr_ok, sys_lock;
  logic [63:0] cycles_nxt, instret_nxt;

  assign rd_res      = csr_rd(csr.rd_addr_i);
  assign wr_res      = csr_rd(csr.wr_addr_i);
  assign wr_old      = wr_res[31:0];
  assign wr_unmapped = wr_res[32];
  assign wr_ro       = csr.wr_addr_i inside {A_MVENDORID, A_MARCHID, A_MIMPID, A_MHARTID, A_MISA,
                                             A_MEDELEG, A_MIDELEG, A_CYCLE, A_TIME, A_CYCLEH, A_TIMEH};
  // RS/RC with a zero source are pure reads: no write, no illegal pulse.
  assign wr_en    = csr.wr_valid_i && (csr.wr_op_i != 2'b00) &&
                    !((csr.wr_op_i != OP_RW) && csr.wr_src_zero_i);
  assign wr_ok    = wr_en && !wr_unmapped && !wr_ro;
  assign sys_lock = csr.trap_i || csr.mret_i;

  always_comb begin
    wr_new = wr_old & ~csr.wr_src_i;
    if (csr.wr_op_i == OP_RW)      wr_new = csr.wr_src_i;
    else if (csr.wr_op_i == OP_RS) wr_new = wr_old | csr.wr_src_i;
  end

  // A write to either half replaces that half and skips the increment this cycle.
  always_comb begin
    cycles_nxt  = cycles + 64'd1;
    instret_nxt = instret + {63'd0, csr.retire_i};
    if (wr_ok && (csr.wr_addr_i == A_MCYCLE || csr.wr_addr_i == A_MTIME))
      cycles_nxt = {cycles[63:32], wr_new};
    else if (wr_ok && (csr.wr_addr_i == A_MCYCLEH || csr.wr_addr_i == A_MTIMEH))
      cycles_nxt = {wr_new, cycles[31:0]};
    if (wr_ok && csr.wr_addr_i == A_MINSTRET)
      instret_nxt = {instret[63:32], wr_new};
    else if (wr_ok && csr.wr_addr_i == A_MINSTRETH)
      instret_nxt = {wr_new, instret[31:0]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles       <= '0;
      instret      <= '0;
      timecmp      <= '1;
      mscratch     <= '0;
      dscratch     <= '0;
      mepc         <= '0;
      mbadaddr     <= '0;
      mtvec        <= MTVEC_RESET;
      mcause_irq   <= 1'b0;
      mcause_code  <= '0;
      mie_g        <= 1'b0;
      mpie         <= 1'b0;
      msip         <= 1'b0;
      mie_en       <= '0;
      wr_illegal_q <= 1'b0;
    end else begin
      wr_illegal_q <= wr_en && (wr_unmapped || wr_ro);
      cycles       <= cycles_nxt;
      instret      <= instret_nxt;
      if (wr_ok) begin
        case (csr.wr_addr_i)
          TIMECMP_ADDR_LO: timecmp[31:0]  <= wr_new;
          TIMECMP_ADDR_HI: timecmp[63:32] <= wr_new;
          A_MSCRATCH:      mscratch       <= wr_new;
          A_DSCRATCH:      dscratch       <= wr_new;
          A_MTVEC:         mtvec          <= wr_new;
          A_MIE:           mie_en         <= {wr_new[11], wr_new[7], wr_new[3]};
          A_MIP:           msip           <= wr_new[3];
          A_MSTATUS:  if (!sys_lock) begin mie_g <= wr_new[3]; mpie <= wr_new[7]; end
          A_MEPC:     if (!sys_lock) mepc     <= wr_new;
          A_MBADADDR: if (!sys_lock) mbadaddr <= wr_new;
          A_MCAUSE:   if (!sys_lock) begin mcause_irq <= wr_new[31]; mcause_code <= wr_new[3:0]; end
          default: ;
        endcase
      end
      if (csr.trap_i) begin
        mepc        <= csr.trap_pc_i;
        mcause_irq  <= csr.trap_cause_i[31];
        mcause_code <= csr.trap_cause_i[3:0];
        mbadaddr    <= csr.trap_tval_i;
        mpie        <= mie_g;
        mie_g       <= 1'b0;
      end else if (csr.mret_i) begin
        mie_g <= mpie;
        mpie  <= 1'b1;
      end
    end
  end

  logic unused_cause;
  assign unused_cause = ^csr.trap_cause_i[30:4];

  assign csr.rd_data_o     = rd_res[31:0];
  assign csr.rd_illegal_o  = rd_res[32];
  assign csr.wr_illegal_o  = wr_illegal_q;
  assign csr.mtvec_o       = {mtvec[31:2], 2'b0};
  assign csr.mepc_o        = {mepc[31:2], 2'b0};
  assign csr.mie_global_o  = mie_g;
  // meip has no source in this core, so only the timer and software bits can fire.
  assign csr.irq_pending_o = mie_g && ((mie_en[1] && mtip) || (mie_en[0] && msip));

endmodule

// File: tb/tb_kamus_csr_file.sv
// Bench for kamus_csr_file: vector table, hand-written corner sequences and a random
// phase, all checked against a register-map model kept in the bench.
module tb_kamus_csr_file;
  localparam logic [31:0] MISA_V  = 32'h4000_0100;
  localparam logic [31:0] MTVEC_R = 32'h0000_2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kamus_csr_file_if bus();
  kamus_csr_file #(.MTVEC_RESET(MTVEC_R)) dut (.clk_i(clk), .rst_ni(rst_n), .csr(bus));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_cyc, m_ins, m_tcmp;
  logic [31:0] m_scr, m_dscr, m_epc, m_bad, m_tvec, m_cause, m_mie;
  bit          m_mieg, m_mpie, m_msip, m_ill;

  task automatic model_reset();
    m_cyc = 0; m_ins = 0; m_tcmp = '1;
    m_scr = 0; m_dscr = 0; m_epc = 0; m_bad = 0; m_cause = 0; m_mie = 0;
    m_tvec = MTVEC_R; m_mieg = 0; m_mpie = 0; m_msip = 0; m_ill = 0;
  endtask

  function automatic bit m_mtip();
    return m_cyc >= m_tcmp;
  endfunction

  function automatic bit m_irq();
    return m_mieg && ((m_mie[7] && m_mtip()) || (m_mie[3] && m_msip));
  endfunction

  task automatic m_read(input logic [11:0] a, output logic [31:0] d, output bit bad);
    d = 0; bad = 0;
    case (a)
      12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h302, 12'h303: d = 0;
      12'h301: d = MISA_V;
      12'h300: d = 32'h1800 | (m_mpie ? 32'h80 : 0) | (m_mieg ? 32'h8 : 0);
      12'h304: d = m_mie;
      12'h344: d = (m_msip ? 32'h8 : 0) | (m_mtip() ? 32'h80 : 0);
      12'h305: d = m_tvec & ~32'h3;
      12'h340: d = m_scr;
      12'h341: d = m_epc & ~32'h3;
      12'h342: d = m_cause;
      12'h343: d = m_bad;
      12'h7B2: d = m_dscr;
      12'hB00, 12'h701, 12'hC00, 12'hC01: d = m_cyc[31:0];
      12'hB80, 12'h741, 12'hC80, 12'hC81: d = m_cyc[63:32];
      12'hB02: d = m_ins[31:0];
      12'hB82: d = m_ins[63:32];
      12'h7C0: d = m_tcmp[31:0];
      12'h7C1: d = m_tcmp[63:32];
      default: bad = 1;
    endcase
  endtask

  task automatic model_step();
    logic [11:0] a;
    logic [31:0] old, nv;
    logic [63:0] nc, ni;
    bit unm, ro, en, ok, lock, pm;
    a  = bus.wr_addr_i;
    en = bus.wr_valid_i && bus.wr_op_i != 0 && !(bus.wr_op_i != 2'b01 && bus.wr_src_zero_i);
    m_read(a, old, unm);
    ro = a inside {12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h301, 12'h302, 12'h303,
                   12'hC00, 12'hC01, 12'hC80, 12'hC81};
    ok = en && !unm && !ro;
    case (bus.wr_op_i)
      2'b01:   nv = bus.wr_src_i;
      2'b10:   nv = old | bus.wr_src_i;
      default: nv = old & ~bus.wr_src_i;
    endcase
    m_ill = en && (unm || ro);
    lock  = bus.trap_i || bus.mret_i;
    nc = m_cyc + 1;
    ni = m_ins + 64'(bus.retire_i);
    if (ok) begin
      case (a)
        12'hB00, 12'h701: nc = {m_cyc[63:32], nv};
        12'hB80, 12'h741: nc = {nv, m_cyc[31:0]};
        12'hB02: ni = {m_ins[63:32], nv};
        12'hB82: ni = {nv, m_ins[31:0]};
        12'h7C0: m_tcmp[31:0] = nv;
        12'h7C1: m_tcmp[63:32] = nv;
        12'h340: m_scr = nv;
        12'h7B2: m_dscr = nv;
        12'h305: m_tvec = nv;
        12'h304: m_mie = nv & 32'h888;
        12'h344: m_msip = nv[3];
        12'h300: if (!lock) begin m_mieg = nv[3]; m_mpie = nv[7]; end
        12'h341: if (!lock) m_epc = nv;
        12'h342: if (!lock) m_cause = nv & 32'h8000_000F;
        12'h343: if (!lock) m_bad = nv;
        default: ;
      endcase
    end
    if (bus.trap_i) begin
      m_epc = bus.trap_pc_i; m_cause = bus.trap_cause_i & 32'h8000_000F;
      m_bad = bus.trap_tval_i; m_mpie = m_mieg; m_mieg = 0;
    end else if (bus.mret_i) begin
      pm = m_mpie; m_mieg = pm; m_mpie = 1;
    end
    m_cyc = nc;
    m_ins = ni;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  task automatic cmp_all(input string tag);
    logic [31:0] d;
    bit bad;
    m_read(bus.rd_addr_i, d, bad);
    chk({tag, "_rd_data"}, bus.rd_data_o, d);
    chk({tag, "_rd_illegal"}, 32'(bus.rd_illegal_o), 32'(bad));
    chk({tag, "_wr_illegal"}, 32'(bus.wr_illegal_o), 32'(m_ill));
    chk({tag, "_irq"}, 32'(bus.irq_pending_o), 32'(m_irq()));
    chk({tag, "_mtvec"}, bus.mtvec_o, m_tvec & ~32'h3);
    chk({tag, "_mepc"}, bus.mepc_o, m_epc & ~32'h3);
    chk({tag, "_mie_g"}, 32'(bus.mie_global_o), 32'(m_mieg));
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    bus.rd_addr_i = 0; bus.wr_valid_i = 0; bus.wr_op_i = 0; bus.wr_addr_i = 0;
    bus.wr_src_i = 0; bus.wr_src_zero_i = 0; bus.retire_i = 0; bus.trap_i = 0;
    bus.trap_pc_i = 0; bus.trap_cause_i = 0; bus.trap_tval_i = 0; bus.mret_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] src,
                    input bit zero);
    bus.wr_valid_i = 1; bus.wr_op_i = op; bus.wr_addr_i = a;
    bus.wr_src_i = src; bus.wr_src_zero_i = zero;
    tick();
    bus.wr_valid_i = 0; bus.wr_op_i = 0; bus.wr_src_zero_i = 0;
  endtask

  task automatic rd(input logic [11:0] a, input string name, input logic [31:0] exp);
    bus.rd_addr_i = a;
    #1;
    chk(name, bus.rd_data_o, exp);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] src;
    bit          zero;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_ill;
  } vec_t;

  vec_t tbl[19];
  logic [11:0] pool[28];

  initial begin
    logic [31:0] v0, c;
    int lat;

    tbl[0]  = '{2'b01, 12'h340, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 0};
    tbl[1]  = '{2'b10, 12'h340, 32'h0000_00F0, 0, 1, 32'hDEAD_BEFF, 0};
    tbl[2]  = '{2'b11, 12'h340, 32'h0000_000F, 0, 1, 32'hDEAD_BEF0, 0};
    tbl[3]  = '{2'b00, 12'h340, 32'h0000_0000, 0, 1, 32'hDEAD_BEF0, 0};
    tbl[4]  = '{2'b11, 12'h340, 32'hFFFF_FFFF, 1, 1, 32'hDEAD_BEF0, 0};
    tbl[5]  = '{2'b01, 12'h300, 32'hFFFF_FFFF, 0, 1, 32'h0000_1888, 0};
    tbl[6]  = '{2'b10, 12'h300, 32'h0000_0000, 1, 1, 32'h0000_1888, 0};
    tbl[7]  = '{2'b01, 12'h304, 32'hFFFF_FFFF, 0, 1, 32'h0000_0888, 0};
    tbl[8]  = '{2'b01, 12'h344, 32'hFFFF_FFFF, 0, 1, 32'h0000_0008, 0};
    tbl[9]  = '{2'b01, 12'h342, 32'hFFFF_FFFF, 0, 1, 32'h8000_000F, 0};
    tbl[10] = '{2'b01, 12'h305, 32'h1234_5677, 0, 1, 32'h1234_5674, 0};
    tbl[11] = '{2'b01, 12'hC00, 32'h0000_0000, 0, 0, 32'h0,         1};
    tbl[12] = '{2'b01, 12'h123, 32'h5555_5555, 0, 1, 32'h0,         1};
    tbl[13] = '{2'b01, 12'hF11, 32'h1111_1111, 0, 1, 32'h0,         1};
    tbl[14] = '{2'b01, 12'h302, 32'hFFFF_FFFF, 0, 1, 32'h0,         1};
    tbl[15] = '{2'b10, 12'hC00, 32'h0000_0000, 1, 0, 32'h0,         0};
    tbl[16] = '{2'b01, 12'h7B2, 32'h0000_55AA, 0, 1, 32'h0000_55AA, 0};
    tbl[17] = '{2'b11, 12'h300, 32'h0000_0008, 0, 1, 32'h0000_1880, 0};
    tbl[18] = '{2'b01, 12'h301, 32'h0000_0000, 0, 1, 32'h4000_0100, 1};

    pool = '{12'h300, 12'h301, 12'h302, 12'h303, 12'h304, 12'h305, 12'h340, 12'h341,
             12'h342, 12'h343, 12'h344, 12'h701, 12'h741, 12'h7B2, 12'h7C0, 12'h7C1,
             12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC01, 12'hC80, 12'hC81,
             12'hF11, 12'hF14, 12'h123, 12'h7FF};

    idle();
    model_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);

    // reset state
    rd(12'h300, "rst_mstatus", 32'h0000_1800);
    rd(12'h340, "rst_mscratch", 32'h0);
    rd(12'h7C0, "rst_tcmp_lo", 32'hFFFF_FFFF);
    rd(12'h7C1, "rst_tcmp_hi", 32'hFFFF_FFFF);
    rd(12'hB00, "rst_cycle", 32'h0);
    chk("rst_mtvec_o", bus.mtvec_o, MTVEC_R);
    chk("rst_irq", 32'(bus.irq_pending_o), 32'h0);
    chk("rst_wr_illegal", 32'(bus.wr_illegal_o), 32'h0);

    rst_n = 1;
    bus.rd_addr_i = 12'hB00;
    #1 v0 = bus.rd_data_o;
    tick(); tick();
    #1 chk("cycle_delta", bus.rd_data_o - v0, 32'd2);
    rd(12'h301, "misa", 32'h4000_0100);
    rd(12'h7C0, "tcmp_lo", 32'hFFFF_FFFF);

    // vector table: apply write, check next-cycle readback and one-cycle illegal pulse
    foreach (tbl[i]) begin
      bus.rd_addr_i = tbl[i].addr;
      wr(tbl[i].op, tbl[i].addr, tbl[i].src, tbl[i].zero);
      #1;
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), bus.rd_data_o, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_ill", i), 32'(bus.wr_illegal_o), 32'(tbl[i].exp_ill));
      cmp_all($sformatf("tbl%0d", i));
      tick();
      #1 chk($sformatf("tbl%0d_ill_clr", i), 32'(bus.wr_illegal_o), 32'h0);
    end

    // illegal write to CYCLE leaves the counter running normally
    bus.rd_addr_i = 12'hC00;
    #1 c = bus.rd_data_o;
    wr(2'b01, 12'hC00, 32'h0, 0);
    #1 chk("cycle_ro_unaffected", bus.rd_data_o, c + 32'd1);
    chk("cycle_ro_ill", 32'(bus.wr_illegal_o), 32'h1);

    // timer interrupt
    wr(2'b01, 12'h344, 32'h0, 0);
    wr(2'b01, 12'h304, 32'h80, 0);
    wr(2'b01, 12'h7C1, 32'h0, 0);
    wr(2'b10, 12'h300, 32'h8, 0);
    #1 chk("timer_idle_irq", 32'(bus.irq_pending_o), 32'h0);
    bus.rd_addr_i = 12'hB00;
    #1 c = bus.rd_data_o;
    wr(2'b01, 12'h7C0, c + 32'd5, 0);
    lat = 1;
    #1;
    while (!bus.irq_pending_o && lat <= 20) begin
      cmp_all("timer_wait");
      tick();
      #1 lat++;
    end
    chk("timer_latency_ok", 32'(lat >= 4 && lat <= 6), 32'h1);
    wr(2'b01, 12'h7C1, 32'h1, 0);
    #1 chk("timer_clear_irq", 32'(bus.irq_pending_o), 32'h0);

    // trap with a colliding mepc write, then MRET
    bus.trap_i = 1; bus.trap_pc_i = 32'h100; bus.trap_cause_i = 32'h8000_0007;
    bus.trap_tval_i = 32'h0000_0BAD;
    wr(2'b01, 12'h341, 32'h0000_DEAD, 0);
    bus.trap_i = 0;
    #1 chk("trap_mepc", bus.mepc_o, 32'h100);
    chk("trap_mie", 32'(bus.mie_global_o), 32'h0);
    chk("trap_no_ill", 32'(bus.wr_illegal_o), 32'h0);
    rd(12'h300, "trap_mstatus", 32'h0000_1880);
    rd(12'h342, "trap_mcause", 32'h8000_0007);
    rd(12'h343, "trap_mbadaddr", 32'h0000_0BAD);
    bus.mret_i = 1;
    tick();
    bus.mret_i = 0;
    #1 chk("mret_mie", 32'(bus.mie_global_o), 32'h1);
    rd(12'h300, "mret_mstatus", 32'h0000_1888);
    bus.trap_i = 1; bus.mret_i = 1;
    tick();
    bus.trap_i = 0; bus.mret_i = 0;
    rd(12'h300, "trap_beats_mret", 32'h0000_1880);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.wr_valid_i    = ($urandom_range(0, 3) != 0);
      bus.wr_op_i       = 2'($urandom_range(0, 3));
      bus.wr_addr_i     = pool[$urandom_range(0, 27)];
      bus.wr_src_i      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      bus.wr_src_zero_i = ($urandom_range(0, 3) == 0);
      bus.retire_i      = 1'($urandom_range(0, 1));
      bus.trap_i        = ($urandom_range(0, 15) == 0);
      bus.mret_i        = ($urandom_range(0, 15) == 0);
      bus.trap_pc_i     = $urandom;
      bus.trap_cause_i  = $urandom;
      bus.trap_tval_i   = $urandom;
      bus.rd_addr_i     = pool[$urandom_range(0, 27)];
      #1 cmp_all("rand");
      tick();
    end
    idle();
    #1 cmp_all("rand_end");

    // reset asserted in the middle of a write
    wr(2'b01, 12'h340, 32'h1234_5678, 0);
    bus.wr_valid_i = 1; bus.wr_op_i = 2'b01; bus.wr_addr_i = 12'h305; bus.wr_src_i = 32'hFFFF_FFF0;
    #2 rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1;
    rd(12'h340, "midrst_mscratch", 32'h0);
    rd(12'hB00, "midrst_cycle", 32'h0);
    chk("midrst_mtvec", bus.mtvec_o, MTVEC_R);
    cmp_all("midrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/kamus_csr_file.md
Name: kamus_csr_file

Overview:
Machine-mode CSR storage and write side of the CSR interface. Holds every CSR that the execute stage reads. Applies CSRRW/CSRRS/CSRRC writes retired from the write-back stage. Maintains the cycle, instret and timer-compare state, handles trap entry/MRET updates, and raises the timer-interrupt pending bit. It also provides the combinational read port that the execute stage uses.

Parameters:
MISA_VALUE, 32'h4000_0100, constant returned for MISA (RV32I).
MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
TIMECMP_ADDR_LO, 12'h7C0, custom address of mtimecmp[31:0].
TIMECMP_ADDR_HI, 12'h7C1, custom address of mtimecmp[63:32].

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
rd_addr_i  in  12  CSR read address (execute stage)
rd_data_o  out  32  combinational read data; 0 for unmapped addresses
rd_illegal_o  out  1  read address unmapped
wr_valid_i  in  1  CSR instruction retiring this cycle
wr_op_i  in  2  01=RW, 10=RS, 11=RC; 00 treated as no write
wr_addr_i  in  12  target CSR
wr_src_i  in  32  rs1 value or zero-extended uimm
wr_src_zero_i  in  1  rs1 index/uimm is zero (RS/RC suppress the write)
wr_illegal_o  out  1  one-cycle pulse: write to read-only or unmapped CSR
retire_i  in  1  any instruction retired this cycle (instret increment)
trap_i  in  1  trap entry this cycle
trap_pc_i  in  32  PC of the trapping instruction
trap_cause_i  in  32  cause ({irq, 27'b0, code[3:0]} is used)
trap_tval_i  in  32  bad address
mret_i  in  1  MRET retiring
mtvec_o  out  32  {mtvec[31:2],2'b0}
mepc_o  out  32  {mepc[31:2],2'b0}
mie_global_o  out  1  mstatus.MIE
irq_pending_o  out  1  (mip & mie) != 0 and mstatus.MIE

Behaviour:
- Reset (async, rst_ni low): cycles=0, instret=0, timecmp=64'hFFFF_FFFF_FFFF_FFFF, mscratch=0, mepc=0, mcause=0, mbadaddr=0, mtvec=MTVEC_RESET, mstatus.MIE=0, MPIE=0, mie={meie,mtie,msie}=0, mip.msip=0, mip.meip=0. Outputs follow: rd_data_o reflects these values; wr_illegal_o=0; irq_pending_o=0.
- Map (read): MVENDORID/MARCHID/MIMPID/MHARTID/MEDELEG/MIDELEG=0; MISA=MISA_VALUE; MSTATUS={19'b0,2'b11,3'b0,MPIE,3'b0,MIE,3'b0}; MIP/MIE bit layout: bits 11/7/3; MCAUSE={mcause[31],27'b0,mcause[3:0]}; MCYCLE/MTIME/CYCLE/TIME=cycles[31:0]; the *H variants return [63:32]; MINSTRET(H), MSCRATCH, MEPC, MBADADDR, DSCRATCH, mtimecmp lo/hi as stored.
- Write, effective when wr_valid_i and op!=00: new = RW ? src : RS ? old|src : old&~src. old is the current register value (read-modify-write in one cycle; update visible next cycle).
- RS/RC with wr_src_zero_i=1: no write and no illegal pulse.
- Read-only (MVENDORID..MHARTID, MISA, CYCLE/TIME/CYCLEH/TIMEH) or unmapped target: no state change; wr_illegal_o=1 for the following cycle only. Writes to read-only MEDELEG/MIDELEG also pulse illegal.
- Writable field masks: mstatus bits 7,3 only; mie bits 11,7,3; mip bit 3 only (mtip is read-only); mcause bits 31,3:0; mtvec/mepc store the full 32 bits, and reads mask [1:0].
- Counters: cycles+=1 every cycle; instret+=retire_i. Both are 64-bit with wrap from all-ones to 0. A CSR write to any half replaces that half and suppresses the increment for that cycle; the other half is unchanged.
- mtip (combinational): cycles >= timecmp (unsigned 64-bit). It clears once timecmp is written above cycles.
- Trap entry: mepc<=trap_pc_i, mcause<=trap_cause_i, mbadaddr<=trap_tval_i, MPIE<=MIE, MIE<=0.
- MRET: MIE<=MPIE, MPIE<=1.
- Priority in one cycle: trap_i > mret_i > CSR write for mstatus/mepc/mcause/mbadaddr; the losing write is dropped without an illegal pulse. trap_i with mret_i both high: trap wins.
- Reset asserted mid-operation: all state returns to reset values immediately. No partial write survives.

Test Plan:
- Reset release, read 0xB00 two cycles apart -> values differ by 2. Read 0x301 -> 32'h4000_0100. Read 0x7C0 -> 32'hFFFF_FFFF.
- CSRRW 0x340 with src=32'hDEAD_BEEF, then CSRRS src=32'h0000_00F0, then CSRRC src=32'h0000_000F -> reads DEADBEEF, DEADBEFF, DEADBEF0.
- CSRRW 0x300 src=32'hFFFF_FFFF -> read 32'h0000_1888. CSRRS 0x300 with wr_src_zero_i=1 -> unchanged, no illegal pulse.
- CSRRW to 0xC00 and to 0x123 -> wr_illegal_o high exactly one cycle each; the cycle counter is unaffected.
- Write mtimecmp={0,cycles+5}, with MIE=1 and mie.mtie=1 -> irq_pending_o rises 5±1 cycles later. Then write mtimecmp hi=1 -> irq_pending_o clears next cycle.
- trap_i (pc=0x100, cause=32'h8000_0007) with a simultaneous CSRRW to mepc -> mepc=0x100, MIE=0, MPIE=old MIE. A subsequent mret_i -> MIE restored, MPIE=1.
